forward_cell_link_arb: RTL and testbench

//  Parametrised successor cell-link forwarder. Merges NUM_IN AXI-Stream packet sources
//  (input 0 = incoming cell link; 1..NUM_IN-1 = local sources) onto one outgoing cell-link stream.

---
 rtl/forward_cell_link_arb_if.sv | 25 ++
 rtl/forward_cell_link_arb.sv | 259 +++++++++++++++++++++++++
 tb/tb_forward_cell_link_arb.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/forward_cell_link_arb_if.sv
// Cell-link forwarder bus bundle: NUM_IN AXI-Stream inputs, input-0 CRC status, outgoing cell-link stream.
// The slave modport is the forwarder's view; the master modport is the sources/sink view.
interface forward_cell_link_arb_if #(
  parameter int NUM_IN = 3
);
  logic [NUM_IN-1:0]    rxTVALID;
  logic [NUM_IN-1:0]    rxTLAST;
  logic [32*NUM_IN-1:0] rxTDATA;
  logic [NUM_IN-1:0]    rxTREADY;
  logic                 cellLinkRxCRCvalid;
  logic                 cellLinkRxCRCpass;
  logic                 cellLinkTxTVALID;
  logic                 cellLinkTxTLAST;
  logic [31:0]          cellLinkTxTDATA;

  modport slave (
    input  rxTVALID, rxTLAST, rxTDATA, cellLinkRxCRCvalid, cellLinkRxCRCpass,
    output rxTREADY, cellLinkTxTVALID, cellLinkTxTLAST, cellLinkTxTDATA
  );

  modport master (
    output rxTVALID, rxTLAST, rxTDATA, cellLinkRxCRCvalid, cellLinkRxCRCpass,
    input  rxTREADY, cellLinkTxTVALID, cellLinkTxTLAST, cellLinkTxTDATA
  );
endinterface

// File: rtl/forward_cell_link_arb.sv
// Packet-boundary round-robin merger of cell-link sources with per-interval duplicate suppression.
// Optional statistics counters are built when FORWARD_CELL_LINK_STATS_EN is defined.
module forward_cell_link_arb #(
  parameter int                      NUM_IN          = 3,
  parameter int                      MAX_CELLS       = 32,
  parameter int                      NUM_PROTO       = 2,
  parameter logic [16*NUM_PROTO-1:0] PROTO_MAGICS    = {16'hB6CF, 16'hA5BE},
  parameter int                      WATCHDOG_CYCLES = 127
) (
  input  logic                   auroraUserClk,
  input  logic                   auroraReset,
  input  logic                   auroraFAstrobe,
  forward_cell_link_arb_if.slave bus
`ifdef FORWARD_CELL_LINK_STATS_EN
  ,
  output logic [15:0]            fwdCount,
  output logic [15:0]            dupCount,
  output logic [15:0]            dropCount,
  output logic [15:0]            timeoutCount
`endif
);
  localparam int CIW = $clog2(MAX_CELLS);
  localparam int GW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int PW  = (NUM_PROTO > 1) ? $clog2(NUM_PROTO) : 1;
  localparam int WW  = 10;
  localparam logic [31:0] TERM_WORD = 32'h4000_0000;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FWD, S_DRAIN, S_TERM} state_t;

  state_t                              state_q, state_d;
  logic [GW-1:0]                       grant_q, grant_d;
  logic [GW-1:0]                       ptr_q, ptr_d;
  logic [WW-1:0]                       wd_q, wd_d;
  logic                                ended_q, ended_d;
  logic [NUM_PROTO-1:0][MAX_CELLS-1:0] bmp_q, bmp_d;
  logic                                tx_vld_q, tx_vld_d;
  logic                                tx_last_q, tx_last_d;
  logic [31:0]                         tx_data_q, tx_data_d;

  logic [NUM_IN-1:0] rdy;
  logic              found;
  logic [GW-1:0]     sel, cand;
  logic [31:0]       beat_data;
  logic              beat_last, beat_acc;
  logic [CIW-1:0]    cell_idx;
  logic              hit, bit_seen;
  logic [PW-1:0]     hit_p;
  logic              ev_fwd, ev_dup, ev_drop, ev_tmo;

  function automatic logic [GW-1:0] add_wrap(input logic [GW-1:0] a, input int unsigned k);
    int unsigned t;
    t = 32'(a) + k;
    if (t >= 32'(NUM_IN)) t = t - 32'(NUM_IN);
    return GW'(t);
  endfunction

  // Failed or missing CRC on the incoming link's last beat is flagged in bit 30.
  function automatic logic [31:0] crc_mark(input logic [31:0] d, input logic link_last,
                                           input logic crc_vld, input logic crc_ok);
    logic [31:0] r;
    r = d;
    if (link_last) r[30] = d[30] | ~crc_vld | ~crc_ok;
    return r;
  endfunction

  always_comb begin
    rdy = '0;
    if (state_q == S_HDR || state_q == S_FWD || state_q == S_DRAIN) rdy[grant_q] = 1'b1;
  end

  assign beat_data = bus.rxTDATA[32*grant_q +: 32];
  assign beat_last = bus.rxTLAST[grant_q];
  assign beat_acc  = bus.rxTVALID[grant_q] & rdy[grant_q];
  assign cell_idx  = beat_data[10 +: CIW];

  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      cand = add_wrap(ptr_q, 32'(i));
      if (!found && bus.rxTVALID[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    hit   = 1'b0;
    hit_p = '0;
    for (int p = 0; p < NUM_PROTO; p++) begin
      if (!hit && beat_data[31:16] == PROTO_MAGICS[16*p +: 16]) begin
        hit   = 1'b1;
        hit_p = PW'(p);
      end
    end
  end

  // A header seen on the strobe cycle is judged against the freshly cleared bitmap.
  assign bit_seen = auroraFAstrobe ? 1'b0 : bmp_q[hit_p][cell_idx];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    wd_d      = wd_q;
    ended_d   = ended_q;
    bmp_d     = auroraFAstrobe ? '0 : bmp_q;
    tx_vld_d  = 1'b0;
    tx_last_d = 1'b0;
    tx_data_d = '0;
    ev_fwd    = 1'b0;
    ev_dup    = 1'b0;
    ev_drop   = 1'b0;
    ev_tmo    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = sel;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (beat_acc) begin
          if (beat_last) begin
            state_d = S_IDLE;
            ptr_d   = add_wrap(grant_q, 32'd1);
            ev_drop = 1'b1;
          end else if (hit && !bit_seen) begin
            bmp_d[hit_p][cell_idx] = 1'b1;
            tx_vld_d  = 1'b1;
            tx_data_d = beat_data;
            wd_d      = '0;
            state_d   = S_FWD;
            ev_fwd    = 1'b1;
          end else begin
            state_d = S_DRAIN;
            ev_dup  = hit;
            ev_drop = ~hit;
          end
        end
      end
      S_FWD: begin
        if (auroraFAstrobe) begin
          tx_vld_d  = 1'b1;
          tx_last_d = 1'b1;
          tx_data_d = TERM_WORD;
          ended_d   = beat_acc & beat_last;
          state_d   = S_TERM;
        end else if (beat_acc) begin
          tx_vld_d  = 1'b1;
          tx_last_d = beat_last;
          tx_data_d = crc_mark(beat_data, (grant_q == '0) && beat_last,
                               bus.cellLinkRxCRCvalid, bus.cellLinkRxCRCpass);
          wd_d      = '0;
          if (beat_last) begin
            state_d = S_IDLE;
            ptr_d   = add_wrap(grant_q, 32'd1);
          end
        end else if (wd_q == WW'(WATCHDOG_CYCLES - 1)) begin
          tx_vld_d  = 1'b1;
          tx_last_d = 1'b1;
          tx_data_d = TERM_WORD;
          ended_d   = 1'b0;
          state_d   = S_TERM;
          ev_tmo    = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_TERM: begin
        state_d = ended_q ? S_IDLE : S_DRAIN;
        if (ended_q) ptr_d = add_wrap(grant_q, 32'd1);
      end
      S_DRAIN: begin
        if (beat_acc && beat_last) begin
          state_d = S_IDLE;
          ptr_d   = add_wrap(grant_q, 32'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      wd_q      <= '0;
      ended_q   <= 1'b0;
      bmp_q     <= '0;
      tx_vld_q  <= 1'b0;
      tx_last_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      ended_q   <= ended_d;
      bmp_q     <= bmp_d;
      tx_vld_q  <= tx_vld_d;
      tx_last_q <= tx_last_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.rxTREADY         = rdy;
  assign bus.cellLinkTxTVALID = tx_vld_q;
  assign bus.cellLinkTxTLAST  = tx_last_q;
  assign bus.cellLinkTxTDATA  = tx_data_q;

`ifdef FORWARD_CELL_LINK_STATS_EN
  logic [15:0] fwd_cnt_q, dup_cnt_q, drop_cnt_q, tmo_cnt_q;
  logic [15:0] fwd_lat_q, dup_lat_q, drop_lat_q, tmo_lat_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic ev);
    return (ev && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  // Counts run over one FA interval and are published at the next strobe.
  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      fwd_cnt_q  <= '0;
      dup_cnt_q  <= '0;
      drop_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      fwd_lat_q  <= '0;
      dup_lat_q  <= '0;
      drop_lat_q <= '0;
      tmo_lat_q  <= '0;
    end else if (auroraFAstrobe) begin
      fwd_lat_q  <= fwd_cnt_q;
      dup_lat_q  <= dup_cnt_q;
      drop_lat_q <= drop_cnt_q;
      tmo_lat_q  <= tmo_cnt_q;
      fwd_cnt_q  <= {15'd0, ev_fwd};
      dup_cnt_q  <= {15'd0, ev_dup};
      drop_cnt_q <= {15'd0, ev_drop};
      tmo_cnt_q  <= {15'd0, ev_tmo};
    end else begin
      fwd_cnt_q  <= sat_inc(fwd_cnt_q, ev_fwd);
      dup_cnt_q  <= sat_inc(dup_cnt_q, ev_dup);
      drop_cnt_q <= sat_inc(drop_cnt_q, ev_drop);
      tmo_cnt_q  <= sat_inc(tmo_cnt_q, ev_tmo);
    end
  end

  assign fwdCount     = fwd_lat_q;
  assign dupCount     = dup_lat_q;
  assign dropCount    = drop_lat_q;
  assign timeoutCount = tmo_lat_q;
`else
  logic stats_unused;
  assign stats_unused = ev_fwd ^ ev_dup ^ ev_drop ^ ev_tmo;
`endif
endmodule

// File: tb/tb_forward_cell_link_arb.sv
// Scoreboard bench for forward_cell_link_arb: a source model pushes expected beats with their due cycle.
module tb_forward_cell_link_arb;
  localparam int NUM_IN = 3;
  localparam int WD     = 127;
  localparam logic [31:0] TERM_W = 32'h4000_0000;

  typedef struct {
    logic        last;
    logic [31:0] data;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic strobe;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   out_cnt = 0;
  exp_t sb[$];
  bit   mbmp[2][32];
  logic [31:0] pw[NUM_IN][16];

  forward_cell_link_arb_if #(.NUM_IN(NUM_IN)) bus();

`ifdef FORWARD_CELL_LINK_STATS_EN
  logic [15:0] fwd_c, dup_c, drop_c, tmo_c;
`endif

  forward_cell_link_arb #(.NUM_IN(NUM_IN)) dut (
    .auroraUserClk  (clk),
    .auroraReset    (rst),
    .auroraFAstrobe (strobe),
    .bus            (bus)
`ifdef FORWARD_CELL_LINK_STATS_EN
    ,
    .fwdCount       (fwd_c),
    .dupCount       (dup_c),
    .dropCount      (drop_c),
    .timeoutCount   (tmo_c)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int proto_of(input logic [15:0] m);
    if (m == 16'hA5BE) return 0;
    if (m == 16'hB6CF) return 1;
    return -1;
  endfunction

  task automatic clear_model();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 32; i++) mbmp[p][i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rdy_onehot0", 64'($onehot0(bus.rxTREADY)), 64'd1);
      if (bus.cellLinkTxTVALID) begin
        out_cnt++;
        if (sb.size() == 0) begin
          chk("sb_unexpected", 64'(sb.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_beat", {31'b0, bus.cellLinkTxTLAST, bus.cellLinkTxTDATA}, {31'b0, e.last, e.data});
          chk("sb_cycle", 64'(cyc), 64'(e.c));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    strobe = 1'b0;
    bus.rxTVALID = '0;
    bus.rxTLAST = '0;
    bus.rxTDATA = '0;
    bus.cellLinkRxCRCvalid = 1'b0;
    bus.cellLinkRxCRCpass = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    clear_model();
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    clear_model();
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic set_pkt(input int src, input logic [15:0] magic, input int idx, input int n,
                         input logic [31:0] last_w);
    pw[src][0] = {magic, 16'h0} | (32'(idx) << 10);
    for (int b = 1; b < n; b++) pw[src][b] = 32'h0000_0100 * 32'(src + 1) + 32'(b);
    pw[src][n-1] = last_w;
  endtask

  // Drives one packet; beats accepted at the edge that takes cyc to c are due on the output at cyc == c.
  task automatic send(input int src, input int n, input int stall, input bit strb,
                      input bit crcv, input bit crcp, output int first_c, output int last_c);
    bit fwd, term, lst;
    int c, hc, p, idx, waited;
    logic [31:0] d;
    fwd = 0; term = 0; first_c = 0; last_c = 0; hc = 0;
    for (int b = 0; b < n; b++) begin
      if (b == 1 && (strb || stall > 0)) begin
        bus.rxTVALID[src] = 1'b0;
        if (strb) begin
          strobe = 1'b1;
          if (fwd) begin sb.push_back('{1'b1, TERM_W, cyc + 1}); term = 1; end
          clear_model();
          @(negedge clk);
          strobe = 1'b0;
        end
        if (stall > 0) begin
          if (fwd && !term && stall >= WD) begin sb.push_back('{1'b1, TERM_W, hc + WD}); term = 1; end
          repeat (stall) @(negedge clk);
        end
      end
      lst = (b == n - 1);
      d = pw[src][b];
      bus.rxTVALID[src] = 1'b1;
      bus.rxTLAST[src] = lst;
      bus.rxTDATA[32*src +: 32] = d;
      if (src == 0) begin bus.cellLinkRxCRCvalid = crcv; bus.cellLinkRxCRCpass = crcp; end
      waited = 0;
      while (!bus.rxTREADY[src] && waited < 400) begin @(negedge clk); waited++; end
      if (!bus.rxTREADY[src]) begin
        chk("ready_timeout", {63'b0, bus.rxTREADY[src]}, 64'd1);
        break;
      end
      c = cyc + 1;
      if (b == 0) begin
        first_c = c; hc = c;
        p = proto_of(d[31:16]);
        idx = int'(d[14:10]);
        fwd = (n > 1) && (p >= 0) && !mbmp[p][idx];
        if (fwd) mbmp[p][idx] = 1'b1;
      end
      last_c = c;
      if (fwd && !term) begin
        if (src == 0 && lst) d[30] = d[30] | ~crcv | ~crcp;
        sb.push_back('{lst, d, c});
      end
      @(negedge clk);
    end
    bus.rxTVALID[src] = 1'b0;
    bus.rxTLAST[src] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: cyc %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int f0, l0, f2, l2, base;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_txvalid", {63'b0, bus.cellLinkTxTVALID}, 64'd0);
    chk("rst_txlast", {63'b0, bus.cellLinkTxTLAST}, 64'd0);
    chk("rst_txdata", {32'b0, bus.cellLinkTxTDATA}, 64'd0);
    chk("rst_ready", {61'b0, bus.rxTREADY}, 64'd0);
    rst = 1'b0;

    // T1: fresh packet on input 1 is forwarded beat for beat
    set_pkt(1, 16'hA5BE, 5, 5, 32'h0000_00AA);
    base = out_cnt;
    send(1, 5, 0, 0, 0, 0, f0, l0);
    settle();
    chk("t1_beats", 64'(out_cnt - base), 64'd5);

    // T2: duplicate dropped in the same interval, forwarded after the strobe
    base = out_cnt;
    send(1, 5, 0, 0, 0, 0, f0, l0);
    settle();
    chk("t2_dup_beats", 64'(out_cnt - base), 64'd0);
    pulse_strobe();
    base = out_cnt;
    send(1, 5, 0, 0, 0, 0, f0, l0);
    settle();
    chk("t2_after_strobe", 64'(out_cnt - base), 64'd5);

    // T3: simultaneous requests from reset, input 0 wins, no interleaving
    do_reset();
    set_pkt(0, 16'hB6CF, 3, 4, 32'h0000_0CC0);
    set_pkt(2, 16'hA5BE, 7, 3, 32'h0000_0DD0);
    base = out_cnt;
    fork
      send(0, 4, 0, 0, 1, 1, f0, l0);
      send(2, 3, 0, 0, 0, 0, f2, l2);
    join
    settle();
    chk("t3_order", {63'b0, (f2 > l0)}, 64'd1);
    chk("t3_beats", 64'(out_cnt - base), 64'd7);

    // T4: CRC marking of the input-0 last word
    set_pkt(0, 16'hB6CF, 9, 3, 32'h0000_2222);
    send(0, 3, 0, 0, 1, 0, f0, l0);
    set_pkt(0, 16'hB6CF, 10, 3, 32'h4000_3333);
    send(0, 3, 0, 0, 1, 1, f0, l0);
    set_pkt(0, 16'hB6CF, 13, 2, 32'h0000_4444);
    send(0, 2, 0, 0, 0, 1, f0, l0);
    settle();

    // T5: stall after header trips the watchdog, remainder drained
    set_pkt(1, 16'hA5BE, 11, 4, 32'h0000_5555);
    base = out_cnt;
    send(1, 4, 130, 0, 0, 0, f0, l0);
    settle();
    chk("t5_beats", 64'(out_cnt - base), 64'd2);

    // T6: strobe mid-packet terminates; unknown magic and single-beat packets dropped
    set_pkt(2, 16'hA5BE, 12, 3, 32'h0000_6666);
    base = out_cnt;
    send(2, 3, 0, 1, 0, 0, f0, l0);
    settle();
    chk("t6_strobe_beats", 64'(out_cnt - base), 64'd2);
    set_pkt(1, 16'h1234, 1, 3, 32'h0000_7777);
    base = out_cnt;
    send(1, 3, 0, 0, 0, 0, f0, l0);
    settle();
    chk("t6_unknown_beats", 64'(out_cnt - base), 64'd0);
    set_pkt(2, 16'hA5BE, 20, 1, 32'h0000_0000);
    pw[2][0] = 32'hA5BE_0000 | (32'd20 << 10);
    base = out_cnt;
    send(2, 1, 0, 0, 0, 0, f0, l0);
    settle();
    chk("t6_single_beats", 64'(out_cnt - base), 64'd0);
    set_pkt(2, 16'hA5BE, 20, 3, 32'h0000_8888);
    base = out_cnt;
    send(2, 3, 0, 0, 0, 0, f0, l0);
    settle();
    chk("t6_after_single", 64'(out_cnt - base), 64'd3);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
